// File: rtl/seg_scan_ctrl.sv
// ============================================================================
// seg_scan_ctrl : time-multiplexed seven-segment scan controller
//   Guarded anode sequencing, leading-zero blanking, frame-aligned updates.
// Revision: 1.0
// ============================================================================
`default_nettype none

module seg_scan_ctrl #(
  parameter int NUM_DIGITS    = 4,
  parameter int REFRESH_DIV   = 50000,
  parameter int GUARD_CYCLES  = 2,
  parameter int BLANK_LEADING = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  output logic [3:0]              digit_data,
  output logic [NUM_DIGITS-1:0]   digit_en_n,
  output logic                    frame_done
);

  localparam int VW      = 4 * NUM_DIGITS;
  localparam int MAX_CNT = (REFRESH_DIV > GUARD_CYCLES) ? REFRESH_DIV : GUARD_CYCLES;
  localparam int CW      = $clog2(MAX_CNT + 1);
  localparam int IW      = $clog2(NUM_DIGITS);

  localparam logic [CW-1:0] REF_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] GRD_LAST = CW'(GUARD_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    S_OFF   = 2'd0,
    S_GUARD = 2'd1,
    S_ON    = 2'd2
  } state_t;

  state_t                state, state_d;
  logic [IW-1:0]         idx, idx_d;
  logic [CW-1:0]         cnt, cnt_d;
  logic [VW-1:0]         active, active_d;
  logic [VW-1:0]         shadow, shadow_d;
  logic                  pending, pending_d;
  logic [3:0]            data_d;
  logic [NUM_DIGITS-1:0] en_n_d;
  logic                  fd_d;
  logic                  frame_edge;
  logic                  zero_above;
  logic [NUM_DIGITS-1:0] lit;

  // A digit stays dark only when it and every more-significant nibble is zero.
  always_comb begin
    zero_above = 1'b1;
    lit        = '1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_above = zero_above && (active[i*4 +: 4] == 4'd0);
      lit[i]     = (i == 0) || (BLANK_LEADING == 0) || !zero_above;
    end
  end

  assign frame_edge = (state == S_ON) && (cnt == REF_LAST) && (idx == IDX_LAST);

  always_comb begin
    state_d   = state;
    idx_d     = idx;
    cnt_d     = cnt;
    active_d  = active;
    shadow_d  = shadow;
    pending_d = pending;
    data_d    = digit_data;
    en_n_d    = digit_en_n;
    fd_d      = 1'b0;

    if (!enable) begin
      state_d = S_OFF;
      idx_d   = '0;
      cnt_d   = '0;
      en_n_d  = '1;
      if (load) begin
        active_d  = value;
        pending_d = 1'b0;
      end else if (pending) begin
        active_d  = shadow;
        pending_d = 1'b0;
      end
    end else begin
      // Mid-frame loads park in the shadow until the frame boundary.
      if (load && (state != S_OFF) && !frame_edge) begin
        shadow_d  = value;
        pending_d = 1'b1;
      end
      case (state)
        S_OFF: begin
          if (load) active_d = value;
          state_d = S_GUARD;
          idx_d   = '0;
          cnt_d   = '0;
          en_n_d  = '1;
          data_d  = active_d[3:0];
        end
        S_GUARD: begin
          en_n_d = '1;
          if (cnt == GRD_LAST) begin
            state_d     = S_ON;
            cnt_d       = '0;
            en_n_d[idx] = ~lit[idx];
          end else begin
            cnt_d = cnt + CW'(1);
          end
        end
        S_ON: begin
          if (cnt == REF_LAST) begin
            state_d = S_GUARD;
            cnt_d   = '0;
            en_n_d  = '1;
            if (idx == IDX_LAST) begin
              idx_d     = '0;
              fd_d      = 1'b1;
              pending_d = 1'b0;
              if (load)         active_d = value;
              else if (pending) active_d = shadow;
            end else begin
              idx_d = idx + IW'(1);
            end
            data_d = active_d[{idx_d, 2'b00} +: 4];
          end else begin
            cnt_d = cnt + CW'(1);
          end
        end
        default: begin
          state_d = S_OFF;
          en_n_d  = '1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_OFF;
      idx        <= '0;
      cnt        <= '0;
      active     <= '0;
      shadow     <= '0;
      pending    <= 1'b0;
      digit_data <= 4'd0;
      digit_en_n <= '1;
      frame_done <= 1'b0;
    end else begin
      state      <= state_d;
      idx        <= idx_d;
      cnt        <= cnt_d;
      active     <= active_d;
      shadow     <= shadow_d;
      pending    <= pending_d;
      digit_data <= data_d;
      digit_en_n <= en_n_d;
      frame_done <= fd_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
// ============================================================================
// tb_seg_scan_ctrl : directed self-checking bench for seg_scan_ctrl
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        load;
  logic [15:0] value;
  logic [3:0]  data, data_nb;
  logic [3:0]  en_n, en_n_nb;
  logic        fd, fd_nb;
  int          pass_cnt = 0;
  int          total    = 0;

  always #5 clk = ~clk;

  seg_scan_ctrl #(
    .NUM_DIGITS(4), .REFRESH_DIV(4), .GUARD_CYCLES(2), .BLANK_LEADING(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .value(value),
    .digit_data(data), .digit_en_n(en_n), .frame_done(fd)
  );

  seg_scan_ctrl #(
    .NUM_DIGITS(4), .REFRESH_DIV(4), .GUARD_CYCLES(2), .BLANK_LEADING(0)
  ) dut_nb (
    .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .value(value),
    .digit_data(data_nb), .digit_en_n(en_n_nb), .frame_done(fd_nb)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One digit slot: 2 guard samples (all dark) then 4 lit samples.
  task automatic slot(input string tag, input logic fd0, input logic [3:0] en,
                      input logic [3:0] en_nb, input logic [3:0] dat,
                      input int ld_at, input logic [15:0] ld_val);
    for (int j = 0; j < 6; j++) begin
      if (j == ld_at) begin
        load  = 1'b1;
        value = ld_val;
      end
      tick();
      load = 1'b0;
      check({tag, "/fd"},      {31'd0, fd},    {31'd0, (j == 0) ? fd0 : 1'b0});
      check({tag, "/fd_nb"},   {31'd0, fd_nb}, {31'd0, (j == 0) ? fd0 : 1'b0});
      check({tag, "/data"},    {28'd0, data},    {28'd0, dat});
      check({tag, "/data_nb"}, {28'd0, data_nb}, {28'd0, dat});
      check({tag, "/en"},      {28'd0, en_n},    {28'd0, (j < 2) ? 4'hF : en});
      check({tag, "/en_nb"},   {28'd0, en_n_nb}, {28'd0, (j < 2) ? 4'hF : en_nb});
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    enable = 1'b0;
    load   = 1'b0;
    value  = 16'h0000;
    #12;
    check("rst/en",   {28'd0, en_n}, 32'hF);
    check("rst/data", {28'd0, data}, 32'h0);
    check("rst/fd",   {31'd0, fd},   32'h0);
    tick();
    rst_n = 1'b1;

    // Idle: load goes straight to active, nothing lights.
    load  = 1'b1;
    value = 16'h1234;
    tick();
    load = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      check("idle/en", {28'd0, en_n}, 32'hF);
      check("idle/fd", {31'd0, fd},   32'h0);
    end

    enable = 1'b1;
    // Frame A: 1234
    slot("A0", 1'b0, 4'hE, 4'hE, 4'h4, -1, 16'h0);
    slot("A1", 1'b0, 4'hD, 4'hD, 4'h3, -1, 16'h0);
    slot("A2", 1'b0, 4'hB, 4'hB, 4'h2, -1, 16'h0);
    slot("A3", 1'b0, 4'h7, 4'h7, 4'h1, -1, 16'h0);
    // Frame B: load ABCD during digit 2 must not tear this frame
    slot("B0", 1'b1, 4'hE, 4'hE, 4'h4, -1, 16'h0);
    slot("B1", 1'b0, 4'hD, 4'hD, 4'h3, -1, 16'h0);
    slot("B2", 1'b0, 4'hB, 4'hB, 4'h2,  3, 16'hABCD);
    slot("B3", 1'b0, 4'h7, 4'h7, 4'h1, -1, 16'h0);
    // Frame C: ABCD
    slot("C0", 1'b1, 4'hE, 4'hE, 4'hD, -1, 16'h0);
    slot("C1", 1'b0, 4'hD, 4'hD, 4'hC, -1, 16'h0);
    slot("C2", 1'b0, 4'hB, 4'hB, 4'hB, -1, 16'h0);
    slot("C3", 1'b0, 4'h7, 4'h7, 4'hA, -1, 16'h0);
    // Frame D: load 0005 on the frame_done edge takes effect immediately
    slot("D0", 1'b1, 4'hE, 4'hE, 4'h5,  0, 16'h0005);
    slot("D1", 1'b0, 4'hF, 4'hD, 4'h0, -1, 16'h0);
    slot("D2", 1'b0, 4'hF, 4'hB, 4'h0, -1, 16'h0);
    slot("D3", 1'b0, 4'hF, 4'h7, 4'h0,  2, 16'h0000);
    // Frame E: value 0 shows a single 0 on digit 0
    slot("E0", 1'b1, 4'hE, 4'hE, 4'h0, -1, 16'h0);

    // Digit 1 of frame E: load 00FF in guard, then drop enable mid-ON
    load  = 1'b1;
    value = 16'h00FF;
    tick();
    load = 1'b0;
    check("E1/g0", {28'd0, en_n}, 32'hF);
    tick();
    check("E1/g1", {28'd0, en_n}, 32'hF);
    for (int k = 0; k < 2; k++) begin
      tick();
      check("E1/on_en",    {28'd0, en_n},    32'hF);
      check("E1/on_en_nb", {28'd0, en_n_nb}, 32'hD);
    end
    enable = 1'b0;
    tick();
    check("dis/en",    {28'd0, en_n},    32'hF);
    check("dis/en_nb", {28'd0, en_n_nb}, 32'hF);
    check("dis/fd",    {31'd0, fd},      32'h0);
    tick();
    tick();
    enable = 1'b1;
    // Frame F: pending 00FF committed by the disable
    slot("F0", 1'b0, 4'hE, 4'hE, 4'hF, -1, 16'h0);
    slot("F1", 1'b0, 4'hD, 4'hD, 4'hF, -1, 16'h0);
    slot("F2", 1'b0, 4'hF, 4'hB, 4'h0, -1, 16'h0);
    slot("F3", 1'b0, 4'hF, 4'h7, 4'h0, -1, 16'h0);

    // Async reset while digit 0 is lit
    tick();
    check("G0/fd", {31'd0, fd}, 32'h1);
    tick();
    tick();
    check("G0/en",   {28'd0, en_n}, 32'hE);
    check("G0/data", {28'd0, data}, 32'hF);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst/en",    {28'd0, en_n},    32'hF);
    check("arst/en_nb", {28'd0, en_n_nb}, 32'hF);
    check("arst/data",  {28'd0, data},    32'h0);
    check("arst/fd",    {31'd0, fd},      32'h0);
    tick();
    check("arst/hold", {28'd0, en_n}, 32'hF);
    rst_n = 1'b1;
    slot("R0", 1'b0, 4'hE, 4'hE, 4'h0, -1, 16'h0);
    slot("R1", 1'b0, 4'hF, 4'hD, 4'h0, -1, 16'h0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller that sits directly upstream of the per-digit seven-segment decoder. It holds a multi-nibble value from the CPU output port and presents one nibble at a time on digit_data, which feeds the decoder's 4-bit data input. It drives the active-low digit enables (anodes) in step with that nibble, with a guard gap against ghosting, optional leading-zero blanking, and tear-free value updates at frame boundaries.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (2..8).
REFRESH_DIV, 50000, cycles each digit is lit (>=1).
GUARD_CYCLES, 2, cycles with all anodes off before each digit is lit (>=1).
BLANK_LEADING, 1, 1 = suppress leading zero digits; digit 0 is never blanked.

Ports:
clk  in  1  system clock; all state updates on posedge.
rst_n  in  1  asynchronous, active-low reset.
enable  in  1  1 = scan; 0 = all digits dark.
load  in  1  single-cycle strobe; captures value.
value  in  4*NUM_DIGITS  hex value; nibble i is shown on digit i (digit 0 = least significant, rightmost).
digit_data  out  4  nibble for the decoder's data input (registered).
digit_en_n  out  NUM_DIGITS  active-low digit enables (registered); bit i lights digit i.
frame_done  out  1  one-cycle pulse at the end of each full scan frame.

Behaviour:
- Reset (async, rst_n=0): state=OFF, idx=0, cycle counter=0, active=0, shadow=0, pending=0, digit_data=0, digit_en_n=all 1, frame_done=0.
- State machine states: OFF, GUARD, ON.
- OFF: digit_en_n all 1. If enable=1, go to GUARD with idx=0 and cnt=0. digit_data is loaded with active[idx*4+:4] on that same edge.
- GUARD: digit_en_n all 1. cnt counts 0..GUARD_CYCLES-1. On the last count, go to ON, clear cnt, and drive digit_en_n[idx]=0 unless the digit is blanked.
- ON: exactly one anode is low, or none if blanked, for REFRESH_DIV cycles. On the last count, go to GUARD with idx=(idx==NUM_DIGITS-1)?0:idx+1, drive digit_data with the nibble for the new idx, and drive all anodes high.
- Anode timing: digit_data always changes at GUARD entry, never while an anode is low. This gives the negedge-registered decoder a settle margin of at least GUARD_CYCLES-0.5 cycles.
- Blank rule (BLANK_LEADING=1): digit i>0 is blanked iff nibbles i..NUM_DIGITS-1 of active are all zero. A value of 0 therefore shows a single "0" on digit 0. With BLANK_LEADING=0, no digit is blanked.
- frame_done pulses for 1 cycle on the ON->GUARD edge that leaves idx=NUM_DIGITS-1.
- load while scanning (enable=1): shadow<=value and pending<=1. active<=shadow and pending<=0 happen on the frame_done edge. The nibble for idx 0 on that edge is taken from the new value, so no frame ever mixes old and new digits.
- load on the frame_done edge: value is written directly to active, bypassing shadow; pending ends 0.
- Multiple loads within one frame: the last one wins.
- load while state=OFF: active<=value immediately; pending stays 0.
- enable deasserted in any state: next edge goes to OFF with idx=0, cnt=0, all anodes high. If pending=1, the shadow value is committed to active on that edge. Re-enabling restarts from digit 0 with the guard gap.
- Counters are sized ceil(log2(max(REFRESH_DIV,GUARD_CYCLES)+1)) bits and never wrap inside a phase.
- Reset mid-frame: all outputs return to their reset values asynchronously; there is no partial frame_done.

Test Plan:
- Reset/idle: NUM_DIGITS=4, REFRESH_DIV=4, GUARD_CYCLES=2, enable=0, load value=16'h1234 -> digit_en_n=4'b1111 throughout; active=1234 on the next edge; frame_done never pulses.
- Basic scan: enable=1 with value 16'h1234 -> per digit, 2 cycles of 4'b1111 then 4 cycles lit. Sequence is 4'b1110/data 4, 4'b1101/3, 4'b1011/2, 4'b0111/1, then repeat. frame_done pulses every 24 cycles. digit_data never changes while any anode is low.
- Leading-zero blanking: value 16'h0005, BLANK_LEADING=1 -> only digit 0 lights (data 5); digits 1-3 keep all anodes high during their ON slots. value 0 -> digit 0 shows 0. BLANK_LEADING=0 -> all four digits light.
- Tear-free update: scan 16'h1234, pulse load=16'hABCD during digit 2 -> digits 2 and 3 still show 2 and 1. The next frame shows D, C, B, A. A load coincident with frame_done takes effect in that next frame.
- enable drop mid-ON of digit 1 with pending load 16'h00FF -> next edge all anodes high. Re-enable shows digit 0 = F after the 2-cycle guard; digits 2 and 3 are blanked.
- Async reset asserted mid-ON -> outputs go to their reset values without a clock edge. After release with enable=1, scan restarts at digit 0 showing 0.
